// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - four-source round-robin bus arbiter with hold limit and registered 4:1 data mux
module bus_arbiter4 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold count the owner may reach before a waiting requester takes over.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [7:0] hold_cnt;
    logic [7:0] hold_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n;

    logic [3:0]       others;
    logic             owner_req;
    logic [3:0]       cand;
    logic [1:0]       winner;
    logic [WIDTH-1:0] bus_mux;

    // First set bit of r at or after position p, searching upward modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Candidate set: everyone when idle, everyone except the current owner when granted.
    always_comb begin
        others    = req & ~gnt;
        owner_req = |(req & gnt);
        cand      = (state == IDLE) ? req : others;
        winner    = rr_pick(cand, ptr);
    end

    // Next-state, grant and hold-count decisions.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                gnt_n = 4'b0000;
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = 4'b0001 << winner;
                    sel_n   = winner;
                    ptr_n   = winner + 2'd1;
                    hold_n  = 8'd0;
                end
            end
            GRANT: begin
                if (req == 4'b0000) begin
                    // Nobody wants the bus: release it, keep sel where it was.
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    hold_n  = 8'd0;
                end else if (!owner_req || ((others != 4'b0000) && (hold_cnt >= HOLD_LAST))) begin
                    // Owner left or used up its turn: hand straight over, no idle bubble.
                    gnt_n  = 4'b0001 << winner;
                    sel_n  = winner;
                    ptr_n  = winner + 2'd1;
                    hold_n = 8'd0;
                end else if (others != 4'b0000) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    // Sole requester keeps counting but never past the limit.
                    hold_n = (hold_cnt >= HOLD_LAST) ? HOLD_LAST : hold_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= |gnt_n;
        end
    end

    // 4:1 bus mux steered by the registered owner index.
    always_comb begin
        bus_mux = d0;
        case (sel)
            2'd0:    bus_mux = d0;
            2'd1:    bus_mux = d1;
            2'd2:    bus_mux = d2;
            default: bus_mux = d3;
        endcase
    end

    // Capture the owner's data each cycle a grant is in effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (|gnt) begin
            q       <= bus_mux;
            q_valid <= 1'b1;
        end else begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 16, data width of each source and of the bus output.
REQ-002 Parameter MAX_HOLD SHALL be: MAX_HOLD, default 8, maximum consecutive grant cycles while another requester waits; legal range 1..255.
REQ-003 Port clk SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst SHALL be: rst  input  1  synchronous, active-high reset.
REQ-005 Port req SHALL be: req  input  4  request per source, bit i = source i, level-sensitive.
REQ-006 Ports d0..d3 SHALL be: d0, d1, d2, d3  input  WIDTH  each source's bus data.
REQ-007 Port gnt SHALL be: gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-008 Port sel SHALL be: sel  output  2  registered index of the current owner, used as the 4:1 bus mux select.
REQ-009 Port q SHALL be: q  output  WIDTH  registered bus data of the owner.
REQ-010 Port q_valid SHALL be: q_valid  output  1  q holds owner data captured on the previous cycle.
REQ-011 Port busy SHALL be: busy  output  1  high whenever gnt is nonzero.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-013 Round-robin pointer ptr (2 bits) SHALL mark the highest-priority source; the winner is the first req bit set at or after ptr, searching upward modulo 4.
REQ-014 IDLE: if req is nonzero at a rising edge, the winner SHALL be granted on that edge, giving gnt/sel/busy one cycle of latency from req; FSM -> GRANT; hold_cnt = 0; ptr = winner+1 (mod 4).
REQ-015 IDLE with req == 0: the FSM SHALL remain in IDLE, with gnt = 0 and busy = 0, and sel SHALL retain its last value.
REQ-016 GRANT, owner req high and no other req: the owner SHALL keep the grant, and hold_cnt SHALL saturate at MAX_HOLD-1.
REQ-017 GRANT, owner req high, another req high, hold_cnt < MAX_HOLD-1: the owner SHALL keep the grant and hold_cnt SHALL increment.
REQ-018 GRANT, owner req high, another req high, hold_cnt == MAX_HOLD-1: the grant SHALL pass at that edge to the round-robin winner among the other requesters (preemption), and hold_cnt SHALL reset to 0.
REQ-019 GRANT, owner req low, other req high: the grant SHALL pass at that edge to the round-robin winner with no idle bubble, and hold_cnt SHALL reset to 0.
REQ-020 GRANT, req == 0: the FSM SHALL go to IDLE and gnt SHALL clear at that edge.
REQ-021 On every handover, ptr SHALL be set to new owner+1 mod 4; index 3 SHALL wrap to 0.
REQ-022 gnt SHALL always be one-hot or zero, and when gnt is nonzero, sel SHALL equal the index of the set bit.
REQ-023 Each edge with gnt nonzero, q SHALL capture d[sel] (the owner in effect during that cycle) and q_valid SHALL be set to 1; otherwise q SHALL hold and q_valid SHALL be set to 0.
REQ-024 With MAX_HOLD = 1 and continuous contention, the grant SHALL rotate every cycle.
REQ-025 A requester that drops req while not the owner SHALL have no effect on the arbitration state.

Reset
REQ-026 When rst is high at an edge: state = IDLE, gnt = 0, sel = 0, q = 0, q_valid = 0, busy = 0, ptr = 0, hold_cnt = 0, regardless of req.
REQ-027 rst asserted mid-grant SHALL drop the grant at that edge; arbitration SHALL resume on the first edge with rst low, from ptr = 0.

Verification
REQ-028 Reset, then req=0100 held -> next edge gnt=0100, sel=2, busy=1; the edge after that q=d2, q_valid=1.
REQ-029 Idle state, ptr=0, req=1111 for 12 cycles, MAX_HOLD=8 -> source 0 owns 8 cycles, then gnt=0010 for 4 cycles; no cycle has gnt=0.
REQ-030 Owner 3, drop req3 while req=0011 remains -> next edge gnt=0001 (wrap 3->0), sel=0, no idle cycle.
REQ-031 MAX_HOLD=1, req=1010 held -> gnt alternates 0010, 1000, 0010 each cycle.
REQ-032 gnt=0100, assert rst for one cycle with req=1111 -> gnt=0, q=0, q_valid=0; next edge after release gnt=0001.
REQ-033 Owner 1 alone, req->0000 -> next edge gnt=0, busy=0, sel stays 1; q_valid falls one edge later.
